// File: rtl/spn_cipher_core.sv
// Iterative keyed substitution-permutation cipher core, one round per clock.
// Build option: define SPN_DECRYPT_EN to add the decrypt path (otherwise in_mode is ignored).
module spn_cipher_core #(
   parameter int WIDTH  = 8,
   parameter int ROUNDS = 4,
   parameter int ROT    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] in_key,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int CW        = $clog2(ROUNDS + 1);
   localparam int NIB       = WIDTH / 4;
   localparam int WHITE_AMT = ROUNDS % WIDTH;
   localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

   // Nibble tables packed with entry 0 in the least significant nibble.
   localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] SINV_TBL = 64'hA970_364B_D21C_8FE5;

   if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("spn_cipher_core: WIDTH must be a multiple of 4 and at least 8");
   end
   if (ROUNDS < 1) begin : g_bad_rounds
      $error("spn_cipher_core: ROUNDS must be at least 1");
   end
   if (ROT <= 0 || ROT >= WIDTH) begin : g_bad_rot
      $error("spn_cipher_core: ROT must satisfy 0 < ROT < WIDTH");
   end

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready and data is held while valid waits.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] blk_q, key_q;
   logic [CW-1:0]    cnt_q;
   logic             is_dec;
   logic             round_last;
   logic [WIDTH-1:0] rk_cur, rk_last, enc_next, round_out, load_blk;
   logic [CW-1:0]    load_cnt;
   int               rk_amt;

   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int amt);
      return (v << amt) | (v >> (WIDTH - amt));
   endfunction

   function automatic logic [WIDTH-1:0] sub_fwd(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < NIB; i++) begin
         r[4*i +: 4] = SBOX_TBL[{v[4*i +: 4], 2'b00} +: 4];
      end
      return r;
   endfunction

`ifdef SPN_DECRYPT_EN
   logic             mode_q;
   logic [WIDTH-1:0] dec_next;

   function automatic logic [WIDTH-1:0] sub_inv(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < NIB; i++) begin
         r[4*i +: 4] = SINV_TBL[{v[4*i +: 4], 2'b00} +: 4];
      end
      return r;
   endfunction

   assign is_dec   = mode_q;
   // Decrypt starts from the last round key and walks the counter down to 0.
   assign dec_next = sub_inv(rotl(blk_q, WIDTH - ROT)) ^ rk_cur;
   assign load_blk = in_mode ? (in_data ^ rotl(in_key, WHITE_AMT)) : in_data;
   assign load_cnt = in_mode ? LAST : '0;
   assign round_out = is_dec ? dec_next : enc_next;
`else
   logic unused_mode;
   logic [63:0] unused_sinv;

   assign unused_mode = in_mode;
   assign unused_sinv = SINV_TBL;
   assign is_dec      = 1'b0;
   assign load_blk    = in_data;
   assign load_cnt    = '0;
   assign round_out   = enc_next;
`endif

   assign rk_amt  = int'(cnt_q) % WIDTH;
   assign rk_cur  = rotl(key_q, rk_amt);
   assign rk_last = rotl(key_q, WHITE_AMT);

   // Output whitening is folded into the final encrypt round.
   always_comb begin
      enc_next = rotl(sub_fwd(blk_q ^ rk_cur), ROT);
      if (cnt_q == LAST) begin
         enc_next = enc_next ^ rk_last;
      end
   end

   assign round_last = is_dec ? (cnt_q == '0) : (cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = RUN;
         RUN:  if (round_last) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_q <= '0;
         key_q <= '0;
         cnt_q <= '0;
`ifdef SPN_DECRYPT_EN
         mode_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  blk_q <= load_blk;
                  key_q <= in_key;
                  cnt_q <= load_cnt;
`ifdef SPN_DECRYPT_EN
                  mode_q <= in_mode;
`endif
               end
            end
            RUN: begin
               blk_q <= round_out;
               if (!round_last) begin
                  cnt_q <= is_dec ? (cnt_q - CW'(1)) : (cnt_q + CW'(1));
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign out_data  = blk_q;

endmodule

// File: doc/spn_cipher_core.md
# spn_cipher_core

Parametrised, iterative substitution-permutation cipher core that extends the 8-bit combinational nibble substitution stage into a multi-round, keyed, handshaked engine. It processes one WIDTH-bit block per transaction, runs one round per clock, and supports encrypt and (optionally) decrypt. It sits between the UART/byte front end and the output buffer of the FPGA cryptosystem.

## Interface
- WIDTH, 8: block and key width in bits; must be a multiple of 4 and at least 8.
- ROUNDS, 4: number of rounds; must be at least 1.
- ROT, 3: left-rotation amount of the permutation layer; must satisfy 0 < ROT < WIDTH.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input block and key are valid.
- in_ready  output  1  core accepts input; high only in IDLE.
- in_data  input  WIDTH  plaintext (encrypt) or ciphertext (decrypt).
- in_key  input  WIDTH  key; sampled only on the input handshake.
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled on the input handshake.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  result block.
- busy  output  1  high in RUN or DONE.

## Operation
- S-box S, applied per nibble, indexed 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2. The inverse Si, indexed 0..F, is 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- Round key: rk_r = rotl(key, r mod WIDTH) for r = 0..ROUNDS.
- Encrypt:
  - Set x = pt.
  - For r = 0..ROUNDS-1: x = rotl(S(x ^ rk_r), ROT).
  - ct = x ^ rk_ROUNDS.
- Decrypt:
  - Set x = ct ^ rk_ROUNDS.
  - For r = ROUNDS-1 down to 0: x = Si(rotr(x, ROT)) ^ rk_r.
  - pt = x.
- Whitening is folded into the load step for decrypt and into the last round for encrypt. No extra cycles are added.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch data, key and mode, clear the round counter, and go to RUN.
  - RUN: perform one round per cycle. After round ROUNDS-1, go to DONE.
  - DONE: out_valid=1 and out_data is stable. On out_ready, go to IDLE.
- Round counter is $clog2(ROUNDS+1) bits wide. It counts up for encrypt and down for decrypt. Round-key rotation amounts wrap modulo WIDTH.
- All datapath arithmetic is XOR or rotation at exactly WIDTH bits; nothing widens.

## Timing
- Reset values:
  - State IDLE, in_ready=1, out_valid=0, out_data=0, busy=0.
  - Internal block, key, mode and counter registers are 0.
- Latency: input handshake at edge N gives out_valid=1 after edge N+ROUNDS.
- Throughput: one block per ROUNDS+2 cycles when out_ready is held high.
- in_ready is 0 in RUN and DONE. in_valid is ignored there, and in_data/in_key may change freely.
- out_valid stays high and out_data stays constant while out_ready=0 (arbitrary stall).
- out_ready in DONE: the handshake completes at that edge, and in_ready is 1 on the next cycle. The core never accepts an input in the same cycle as the output handshake.
- out_ready outside DONE is ignored.
- rst asserted mid-RUN or mid-DONE: the result is discarded, state returns immediately to IDLE, and out_valid drops asynchronously.
- in_ready, out_valid and busy are decoded from state registers only, with no combinational input-to-output path.

## Configuration
- SPN_DECRYPT_EN defined: decrypt path, Si, and rotr are built, and in_mode selects the direction.
- SPN_DECRYPT_EN undefined: only encrypt logic is built. in_mode is ignored and the core always encrypts. Latency is identical.

## Test plan
- Reset then idle, defaults (WIDTH=8, ROUNDS=4, ROT=3) -> in_ready=1, out_valid=0, out_data=0x00, busy=0.
- Encrypt pt=0x00, key=0x00 -> out_data=0x66, with out_valid exactly 4 cycles after the handshake.
- Encrypt pt=0x00, key=0xFF -> out_data=0x55. With SPN_DECRYPT_EN, decrypt 0x55 with key 0xFF -> 0x00, and decrypt 0x66 with key 0x00 -> 0x00.
- out_ready held low 10 cycles in DONE -> out_valid and out_data are stable throughout, a second in_valid is not accepted, and in_ready=0.
- rst pulsed 2 cycles after an accept -> out_valid never rises, state is IDLE, and a following encrypt of 0x00 with key 0xFF returns 0x55 normally.
- Back-to-back transactions with out_ready=1 and in_valid=1 continuously -> accepts are spaced exactly ROUNDS+2 cycles apart. Compare against a random 200-vector reference model that covers both modes and WIDTH=16, ROUNDS=7, ROT=5.
